// File: rtl/picorv32_ahb_pkg.sv
// Shared AHB encodings, FSM state type and lane-swap helper for the PicoRV32 AHB bridge.
package picorv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } xfer_state_e;

    // Reverse the four byte lanes of a word.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ahb_single_xfer_engine.sv
// Sequences one AHB SINGLE transfer: bus request, address phase, data phase,
// then a one-cycle completion. RETRY/SPLIT loop back to re-request the bus.
module ahb_single_xfer_engine
    import picorv32_ahb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,        // request accepted this cycle (only honoured in IDLE)
    input  logic       bypass,       // complete without touching the bus
    input  logic       i_hgrant,
    input  logic       i_hready,
    input  logic [1:0] i_hresp,
    output logic       idle,
    output logic       o_hbusreq,
    output logic [1:0] o_htrans,
    output logic       done,
    output logic       rdata_load,   // data phase finished OKAY: take hrdata
    output logic       rdata_clear   // error or bypass: return zero
);

    xfer_state_e state_q, state_d;
    logic        hbusreq_q, hbusreq_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        done_q, done_d;

    // Next state, plus bus outputs decoded from the next state so they come out of flops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = bypass ? ST_DONE : ST_REQ;
            ST_REQ:  if (i_hgrant && i_hready) state_d = ST_ADDR;
            ST_ADDR: if (i_hready) state_d = ST_DATA;
            ST_DATA: begin
                if (i_hresp == HRESP_OKAY) begin
                    if (i_hready) state_d = ST_DONE;
                end else if (i_hresp == HRESP_ERROR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;   // RETRY / SPLIT: reissue the same transfer
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        hbusreq_d = (state_d == ST_REQ);
        htrans_d  = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        done_d    = (state_d == ST_DONE);
    end

    // FSM state and registered bus/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hbusreq_q <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hbusreq_q <= hbusreq_d;
            htrans_q  <= htrans_d;
            done_q    <= done_d;
        end
    end

    assign idle        = (state_q == ST_IDLE);
    assign o_hbusreq   = hbusreq_q;
    assign o_htrans    = htrans_q;
    assign done        = done_q;
    assign rdata_load  = (state_q == ST_DATA) && i_hready && (i_hresp == HRESP_OKAY);
    assign rdata_clear = ((state_q == ST_DATA) && (i_hresp == HRESP_ERROR)) ||
                         (idle && start && bypass);

endmodule

// File: rtl/picorv32_ahb_bridge.sv
// PicoRV32 native memory port to AHB master bridge: one SINGLE transfer per request.
// Strobe decode and byte-lane swapping live here; sequencing is in the engine.
module picorv32_ahb_bridge
    import picorv32_ahb_pkg::*;
#(
    parameter bit BIG_ENDIAN_AHB = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        i_hgrant,
    input  logic        i_hready,
    input  logic [1:0]  i_hresp,
    input  logic [31:0] i_hrdata,
    output logic        o_hbusreq,
    output logic [31:0] o_haddr,
    output logic [1:0]  o_htrans,
    output logic        o_hwrite,
    output logic [2:0]  o_hsize,
    output logic [2:0]  o_hburst,
    output logic [31:0] o_hwdata,
    output logic [3:0]  o_hprot,
    output logic        o_hlock
);

    logic        eng_idle, accept, rdata_load, rdata_clear;
    logic [31:0] dec_addr;
    logic [2:0]  dec_size;
    logic        dec_ok;

    logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;
    logic [3:0]  hprot_q, hprot_d;

    assign accept = eng_idle && mem_valid && enable;

    // Map the Pico byte strobes onto an AHB address and transfer size.
    always_comb begin
        dec_ok   = 1'b1;
        dec_addr = {mem_addr[31:2], 2'b00};
        dec_size = HSIZE_WORD;
        case (mem_wstrb)
            4'b0000, 4'b1111: ;
            4'b0011: dec_size = HSIZE_HALF;
            4'b1100: begin dec_addr = {mem_addr[31:2], 2'b10}; dec_size = HSIZE_HALF; end
            4'b0001: dec_size = HSIZE_BYTE;
            4'b0010: begin dec_addr = {mem_addr[31:2], 2'b01}; dec_size = HSIZE_BYTE; end
            4'b0100: begin dec_addr = {mem_addr[31:2], 2'b10}; dec_size = HSIZE_BYTE; end
            4'b1000: begin dec_addr = {mem_addr[31:2], 2'b11}; dec_size = HSIZE_BYTE; end
            default: dec_ok = 1'b0;
        endcase
    end

    // Transfer attributes are latched at capture and held for the whole transfer,
    // so a RETRY/SPLIT reissue drives an identical address phase.
    always_comb begin
        haddr_d  = haddr_q;
        hsize_d  = hsize_q;
        hwrite_d = hwrite_q;
        hprot_d  = hprot_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        if (accept && dec_ok) begin
            haddr_d  = dec_addr;
            hsize_d  = dec_size;
            hwrite_d = (mem_wstrb != 4'b0000);
            hprot_d  = {2'b00, 1'b1, ~mem_instr};
            hwdata_d = BIG_ENDIAN_AHB ? bswap32(mem_wdata) : mem_wdata;
        end
        if (rdata_clear)
            rdata_d = '0;
        else if (rdata_load)
            rdata_d = BIG_ENDIAN_AHB ? bswap32(i_hrdata) : i_hrdata;
    end

    // Address/data-phase attribute and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            haddr_q  <= '0;
            hsize_q  <= HSIZE_WORD;
            hwrite_q <= 1'b0;
            hprot_q  <= 4'b0011;
            hwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            hwrite_q <= hwrite_d;
            hprot_q  <= hprot_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    ahb_single_xfer_engine u_engine (
        .clk         (clk),
        .reset       (reset),
        .start       (accept),
        .bypass      (~dec_ok),
        .i_hgrant    (i_hgrant),
        .i_hready    (i_hready),
        .i_hresp     (i_hresp),
        .idle        (eng_idle),
        .o_hbusreq   (o_hbusreq),
        .o_htrans    (o_htrans),
        .done        (mem_ready),
        .rdata_load  (rdata_load),
        .rdata_clear (rdata_clear)
    );

    assign mem_rdata = rdata_q;
    assign o_haddr   = haddr_q;
    assign o_hsize   = hsize_q;
    assign o_hwrite  = hwrite_q;
    assign o_hprot   = hprot_q;
    assign o_hwdata  = hwdata_q;
    assign o_hburst  = HBURST_SINGLE;
    assign o_hlock   = 1'b0;

endmodule

// File: tb/tb_picorv32_ahb_bridge.sv
// Directed bench for picorv32_ahb_bridge; a little-endian and a big-endian
// instance run in lockstep on the same stimulus.
module tb_picorv32_ahb_bridge;

    logic        clk = 1'b0;
    logic        reset, enable, mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata, i_hrdata;
    logic [3:0]  mem_wstrb;
    logic        i_hgrant, i_hready;
    logic [1:0]  i_hresp;

    logic        mem_ready, o_hbusreq, o_hwrite, o_hlock;
    logic [31:0] mem_rdata, o_haddr, o_hwdata;
    logic [1:0]  o_htrans;
    logic [2:0]  o_hsize, o_hburst;
    logic [3:0]  o_hprot;

    logic        mem_ready_be, o_hbusreq_be, o_hwrite_be, o_hlock_be;
    logic [31:0] mem_rdata_be, o_haddr_be, o_hwdata_be;
    logic [1:0]  o_htrans_be;
    logic [2:0]  o_hsize_be, o_hburst_be;
    logic [3:0]  o_hprot_be;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    picorv32_ahb_bridge #(.BIG_ENDIAN_AHB(1'b0)) u_le (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .i_hgrant(i_hgrant), .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata),
        .o_hbusreq(o_hbusreq), .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite),
        .o_hsize(o_hsize), .o_hburst(o_hburst), .o_hwdata(o_hwdata), .o_hprot(o_hprot),
        .o_hlock(o_hlock)
    );

    picorv32_ahb_bridge #(.BIG_ENDIAN_AHB(1'b1)) u_be (
        .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready_be), .mem_rdata(mem_rdata_be),
        .i_hgrant(i_hgrant), .i_hready(i_hready), .i_hresp(i_hresp), .i_hrdata(i_hrdata),
        .o_hbusreq(o_hbusreq_be), .o_haddr(o_haddr_be), .o_htrans(o_htrans_be), .o_hwrite(o_hwrite_be),
        .o_hsize(o_hsize_be), .o_hburst(o_hburst_be), .o_hwdata(o_hwdata_be), .o_hprot(o_hprot_be),
        .o_hlock(o_hlock_be)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one sampling edge; returns in cycle 1.
    task automatic req(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input logic ins);
        mem_addr  = a;
        mem_wdata = w;
        mem_wstrb = s;
        mem_instr = ins;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        i_hgrant = 1'b0; i_hready = 1'b1; i_hresp = 2'b00; i_hrdata = '0;
        repeat (3) tick();

        // reset values
        chk("rst_ready", mem_ready, 0);       chk("rst_rdata", mem_rdata, 0);
        chk("rst_busreq", o_hbusreq, 0);      chk("rst_htrans", o_htrans, 0);
        chk("rst_haddr", o_haddr, 0);         chk("rst_hwrite", o_hwrite, 0);
        chk("rst_hsize", o_hsize, 3'b010);    chk("rst_hburst", o_hburst, 0);
        chk("rst_hwdata", o_hwdata, 0);       chk("rst_hprot", o_hprot, 4'b0011);
        chk("rst_hlock", o_hlock, 0);
        reset = 1'b0;
        tick();

        // halfword write (upper half), instruction, zero wait
        req(32'h8000_0000, 32'hF0FF_0FAA, 4'b1100, 1'b1);
        chk("hw_busreq", o_hbusreq, 1);       chk("hw_req_htrans", o_htrans, 0);
        i_hgrant = 1'b1;
        tick();
        chk("hw_htrans", o_htrans, 2'b10);    chk("hw_haddr", o_haddr, 32'h8000_0002);
        chk("hw_hsize", o_hsize, 3'b001);     chk("hw_hwrite", o_hwrite, 1);
        chk("hw_hprot", o_hprot, 4'b0010);    chk("hw_addr_busreq", o_hbusreq, 0);
        chk("hw_haddr_be", o_haddr_be, 32'h8000_0002);
        tick();
        chk("hw_data_htrans", o_htrans, 0);   chk("hw_hwdata", o_hwdata, 32'hF0FF_0FAA);
        chk("hw_hwdata_be", o_hwdata_be, 32'hAA0F_FFF0);
        chk("hw_data_ready", mem_ready, 0);
        tick();
        chk("hw_ready", mem_ready, 1);
        tick();
        chk("hw_ready_off", mem_ready, 0);

        // word read with grant withheld for one extra cycle
        i_hgrant = 1'b0;
        i_hrdata = 32'h1234_5678;
        req(32'h0000_1006, 32'h0, 4'b0000, 1'b0);
        chk("rd_busreq", o_hbusreq, 1);
        tick();
        chk("rd_nogrant_busreq", o_hbusreq, 1); chk("rd_nogrant_htrans", o_htrans, 0);
        i_hgrant = 1'b1;
        tick();
        chk("rd_htrans", o_htrans, 2'b10);    chk("rd_haddr", o_haddr, 32'h0000_1004);
        chk("rd_hsize", o_hsize, 3'b010);     chk("rd_hwrite", o_hwrite, 0);
        chk("rd_hprot", o_hprot, 4'b0011);
        tick();
        tick();
        chk("rd_ready", mem_ready, 1);        chk("rd_rdata", mem_rdata, 32'h1234_5678);
        chk("rd_rdata_be", mem_rdata_be, 32'h7856_3412);
        tick();

        // byte write, lane 2, two data-phase wait states
        req(32'h0000_0010, 32'h0055_0000, 4'b0100, 1'b0);
        tick();
        chk("bw_haddr", o_haddr, 32'h0000_0012); chk("bw_hsize", o_hsize, 3'b000);
        chk("bw_hwrite", o_hwrite, 1);
        tick();
        i_hready = 1'b0;
        chk("bw_hwdata0", o_hwdata, 32'h0055_0000);
        tick();
        chk("bw_hwdata1", o_hwdata, 32'h0055_0000); chk("bw_wait_ready1", mem_ready, 0);
        tick();
        i_hready = 1'b1;
        chk("bw_hwdata2", o_hwdata, 32'h0055_0000); chk("bw_wait_ready2", mem_ready, 0);
        tick();
        chk("bw_ready", mem_ready, 1);
        tick();
        chk("bw_ready_off", mem_ready, 0);

        // RETRY in the data phase, then OKAY on the reissue
        req(32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        tick();
        chk("rt_htrans0", o_htrans, 2'b10);   chk("rt_haddr0", o_haddr, 32'h0000_0020);
        tick();
        i_hresp = 2'b10; i_hready = 1'b0;
        tick();
        chk("rt_rebusreq", o_hbusreq, 1);     chk("rt_req_htrans", o_htrans, 0);
        chk("rt_no_ready", mem_ready, 0);
        i_hresp = 2'b00; i_hready = 1'b1;
        tick();
        chk("rt_htrans1", o_htrans, 2'b10);   chk("rt_haddr1", o_haddr, 32'h0000_0020);
        chk("rt_hwrite1", o_hwrite, 1);       chk("rt_hsize1", o_hsize, 3'b010);
        tick();
        chk("rt_hwdata", o_hwdata, 32'hDEAD_BEEF); chk("rt_data_ready", mem_ready, 0);
        tick();
        chk("rt_ready", mem_ready, 1);
        tick();
        chk("rt_ready_off", mem_ready, 0);

        // read data lane order in both endian modes
        i_hrdata = 32'hAABB_CCDD;
        req(32'h0000_0040, 32'h0, 4'b0000, 1'b0);
        tick(); tick(); tick();
        chk("be_ready", mem_ready_be, 1);
        chk("be_rdata_le", mem_rdata, 32'hAABB_CCDD);
        chk("be_rdata_be", mem_rdata_be, 32'hDDCC_BBAA);
        tick();

        // ERROR response completes with zero read data
        i_hrdata = 32'hFFFF_FFFF;
        req(32'h0000_0050, 32'h0, 4'b0000, 1'b0);
        tick(); tick();
        i_hresp = 2'b01; i_hready = 1'b0;
        tick();
        chk("er_ready", mem_ready, 1);        chk("er_rdata", mem_rdata, 32'h0);
        i_hresp = 2'b00; i_hready = 1'b1;
        tick();
        chk("er_ready_off", mem_ready, 0);

        // unsupported strobe pattern: no bus access, ready next cycle
        req(32'h0000_0060, 32'h0000_0011, 4'b0101, 1'b0);
        chk("bs_ready", mem_ready, 1);        chk("bs_busreq", o_hbusreq, 0);
        tick();
        chk("bs_ready_off", mem_ready, 0);    chk("bs_htrans", o_htrans, 0);

        // enable low blocks new requests
        enable = 1'b0; mem_valid = 1'b1; mem_wstrb = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("en_busreq", o_hbusreq, 0);   chk("en_ready", mem_ready, 0);
        end
        mem_valid = 1'b0; enable = 1'b1;
        tick();

        // reset in the data phase aborts the transfer
        i_hrdata = 32'h5A5A_5A5A;
        req(32'h1000_0000, 32'h1234_5678, 4'b1111, 1'b1);
        tick(); tick();
        chk("ra_in_data_hwdata", o_hwdata, 32'h1234_5678);
        reset = 1'b1;
        tick();
        chk("ra_ready", mem_ready, 0);        chk("ra_busreq", o_hbusreq, 0);
        chk("ra_htrans", o_htrans, 0);        chk("ra_haddr", o_haddr, 0);
        chk("ra_hwrite", o_hwrite, 0);        chk("ra_hsize", o_hsize, 3'b010);
        chk("ra_hprot", o_hprot, 4'b0011);    chk("ra_hwdata", o_hwdata, 0);
        chk("ra_rdata", mem_rdata, 0);
        reset = 1'b0;
        tick();
        chk("ra_ready_after1", mem_ready, 0);
        tick();
        chk("ra_ready_after2", mem_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/picorv32_ahb_bridge.md
Name: picorv32_ahb_bridge

Overview:
- Bridges the PicoRV32 native memory interface (valid/ready) to an AHB bus master port.
- Each Pico request becomes exactly one AHB SINGLE transfer: bus request, grant, address phase, then data phase.
- Sits between the PicoRV32 core and the AHB arbiter/slaves in the GRLIB-based SoC.
- Only one transfer is outstanding at a time.

Parameters:
- BIG_ENDIAN_AHB, 0: 1 means byte-swap write data and read data between the Pico lanes and the AHB lanes.

Ports:
- clk in 1: single clock, all logic on the rising edge.
- reset in 1: synchronous, active-high.
- enable in 1: when 0, no new request is accepted; an in-flight transfer still completes.
- mem_valid in 1: Pico request valid.
- mem_instr in 1: request is an instruction fetch.
- mem_addr in 32: byte address.
- mem_wdata in 32: write data, Pico lane order.
- mem_wstrb in 4: byte strobes; 0000 means read.
- mem_ready out 1: one-cycle completion pulse.
- mem_rdata out 32: read data, valid while mem_ready=1.
- i_hgrant in 1, i_hready in 1, i_hresp in 2, i_hrdata in 32: AHB inputs.
- o_hbusreq out 1, o_haddr out 32, o_htrans out 2, o_hwrite out 1, o_hsize out 3, o_hburst out 3, o_hwdata out 32, o_hprot out 4, o_hlock out 1: AHB outputs.

Behaviour:
- Reset values:
  - mem_ready=0, mem_rdata=0, o_hbusreq=0.
  - o_htrans=IDLE(00), o_haddr=0, o_hwrite=0, o_hsize=010, o_hburst=000, o_hwdata=0, o_hprot=0011, o_hlock=0.
  - FSM returns to IDLE.
  - Reset mid-transfer aborts without a mem_ready pulse.
- Request capture: in IDLE, mem_valid=1 and enable=1 latches addr, wdata, wstrb and instr. A request is sampled only in IDLE.
- Strobe decode (AHB address / hsize):
  - 0000: read, addr[31:2],00 / 010.
  - 1111: write, addr[31:2],00 / 010.
  - 0011: addr[31:2],00 / 001.
  - 1100: addr[31:2],10 / 001.
  - 0001, 0010, 0100, 1000: addr[31:2] plus byte offset 0, 1, 2 or 3 / 000.
  - Any other pattern: no bus access; mem_ready is pulsed the cycle after capture.
- Fixed fields:
  - o_hburst=SINGLE(000), o_hlock=0.
  - o_hprot = {00, 1 (privileged), ~mem_instr}.
- FSM states: IDLE, REQ, ADDR, DATA, DONE.
  - IDLE -> REQ on capture.
  - REQ: o_hbusreq=1, o_htrans=IDLE. Go to ADDR at an edge where i_hgrant=1 and i_hready=1.
  - ADDR: o_htrans=NONSEQ(10), o_haddr/o_hsize/o_hwrite/o_hprot driven, o_hbusreq=0. Advance to DATA at the edge where i_hready=1; otherwise hold all address-phase signals.
  - DATA: o_htrans=IDLE, o_hwdata = the byte-lane write data, held until i_hready=1.
    - i_hready=1 with i_hresp=OKAY(00): capture i_hrdata (swapped if BIG_ENDIAN_AHB) into mem_rdata, go to DONE.
    - i_hresp=ERROR(01): complete via DONE with mem_rdata=0 and the write dropped.
    - i_hresp=RETRY(10) or SPLIT(11): return to REQ and reissue the identical transfer.
  - DONE: mem_ready=1 for exactly one cycle, then IDLE.
- Latency: with grant and zero wait states, mem_valid is sampled at edge 0, o_hbusreq=1 in cycle 1, address phase in cycle 2, data phase in cycle 3, mem_ready=1 in cycle 4.
- Wait states add 1:1 cycles. Grant withheld keeps the block in REQ with o_hbusreq=1.
- Endianness:
  - BIG_ENDIAN_AHB=0: o_hwdata=mem_wdata and mem_rdata=i_hrdata.
  - BIG_ENDIAN_AHB=1: both are byte-reversed ({b0,b1,b2,b3}).
  - Addresses are identical in both modes.
- Deasserting enable mid-transfer has no effect until IDLE.

Decomposition:
- Shared package picorv32_ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/ERROR/RETRY/SPLIT.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_SINGLE.
  - FSM state enum.
- One natural sub-module: ahb_single_xfer_engine, holding the REQ/ADDR/DATA sequencing and response handling.
- Strobe decode and endianness swap stay in the top level.

Test Plan:
- Halfword write, zero wait:
  - Stimulus: mem_addr=0x8000_0000, mem_wdata=0xF0FF_0FAA, mem_wstrb=1100, mem_instr=1, mem_valid=1; grant, hready=1 and hresp=00 given once o_hbusreq=1.
  - Response: o_haddr=0x8000_0002, o_hsize=001, o_hwrite=1, o_htrans=10 for one cycle, then o_hwdata=0xF0FF_0FAA, then a single mem_ready pulse; o_hprot=0010.
- Word read:
  - Stimulus: addr 0x0000_1006, wstrb 0000, i_hrdata=0x1234_5678.
  - Response: o_haddr=0x0000_1004, o_hsize=010, o_hwrite=0, mem_rdata=0x1234_5678 with mem_ready.
- Byte write with 2 wait states:
  - Stimulus: wstrb 0100, addr 0x10.
  - Response: o_haddr=0x12, o_hsize=000, o_hwdata held for 3 cycles, mem_ready 2 cycles later than the zero-wait case.
- RETRY then OKAY:
  - Response: o_hbusreq reasserts, the identical address phase reissues, and only one mem_ready pulse occurs.
- BIG_ENDIAN_AHB=1 read:
  - Stimulus: i_hrdata=0xAABB_CCDD.
  - Response: mem_rdata=0xDDCC_BBAA.
- Gating and reset:
  - enable=0 with mem_valid=1: no o_hbusreq, no mem_ready.
  - reset during DATA: outputs return to their reset values and no mem_ready occurs.
